pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage core. It watches the instruction leaving decode, the instruction in execute (dec_alu_buf outputs) and memory-stage busy requests. It drives the enable, flush and bubble controls of the fetch/decode, decode/ALU and ALU/mem buffers. State is registered on the rising edge of clk, so its controls are settled before the buffers capture on the falling edge.

---
 rtl/core_pkg.sv | 12 +
 rtl/hazard_cmp.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register-index width and the stall/flush controller state encoding.
package core_pkg;

    localparam int unsigned RegIdxW = 3;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemStall  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Combinational load-use detector.
// Flags when the instruction in execute is a load whose destination is read by the instruction
// leaving decode.
//   dec_rsrc1_i/dec_rsrc2_i   : decode source registers
//   dec_src1_used_i/..2_used_i: decode actually reads that source
//   ex_rdst_i                 : execute destination register
//   ex_mem_read_i, ex_wb_en_i : execute is a load that writes the register file
//   load_use_o                : dependent instruction must wait one cycle
module hazard_cmp
    import core_pkg::*;
(
    input  logic [RegIdxW-1:0] dec_rsrc1_i,
    input  logic [RegIdxW-1:0] dec_rsrc2_i,
    input  logic               dec_src1_used_i,
    input  logic               dec_src2_used_i,
    input  logic [RegIdxW-1:0] ex_rdst_i,
    input  logic               ex_mem_read_i,
    input  logic               ex_wb_en_i,
    output logic               load_use_o
);

    logic hit1, hit2;

    assign hit1       = dec_src1_used_i & (dec_rsrc1_i == ex_rdst_i);
    assign hit2       = dec_src2_used_i & (dec_rsrc2_i == ex_rdst_i);
    assign load_use_o = ex_mem_read_i & ex_wb_en_i & (hit1 | hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core.
// State updates on the rising edge so buffer controls are settled before the falling-edge capture.
//   clk, rst                : core clock, synchronous active-high reset
//   i_dec_* / i_ex_*        : decode sources and execute destination for load-use detection
//   i_branch_taken          : execute resolved a taken control transfer
//   i_mem_multi             : mem stage starts a multi-cycle access
//   o_fetch_en, o_fd_*      : PC enable, fetch/decode buffer enable and flush
//   o_dx_en, o_dx_bubble    : decode/ALU buffer enable and control-field bubble
//   o_xm_en                 : ALU/mem buffer enable
//   o_stall_cycles          : saturating count of cycles with fetch disabled
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MemCycles = 2,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RegIdxW-1:0]  i_dec_Rsrc1,
    input  logic [RegIdxW-1:0]  i_dec_Rsrc2,
    input  logic                i_dec_src1_used,
    input  logic                i_dec_src2_used,
    input  logic [RegIdxW-1:0]  i_ex_Rdst,
    input  logic                i_ex_mem_read,
    input  logic                i_ex_wb_en,
    input  logic                i_branch_taken,
    input  logic                i_mem_multi,
    output logic                o_fetch_en,
    output logic                o_fd_en,
    output logic                o_fd_flush,
    output logic                o_dx_en,
    output logic                o_dx_bubble,
    output logic                o_xm_en,
    output logic [CntWidth-1:0] o_stall_cycles
);

    // Frozen cycles still to come after the request cycle.
    localparam logic [3:0] MemLoad = 4'(MemCycles - 2);

    hz_state_e           state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [CntWidth-1:0] stall_q, stall_d;
    logic                load_use;

    hazard_cmp u_hazard_cmp (
        .dec_rsrc1_i     (i_dec_Rsrc1),
        .dec_rsrc2_i     (i_dec_Rsrc2),
        .dec_src1_used_i (i_dec_src1_used),
        .dec_src2_used_i (i_dec_src2_used),
        .ex_rdst_i       (i_ex_Rdst),
        .ex_mem_read_i   (i_ex_mem_read),
        .ex_wb_en_i      (i_ex_wb_en),
        .load_use_o      (load_use)
    );

    always_comb begin
        o_fetch_en  = 1'b1;
        o_fd_en     = 1'b1;
        o_fd_flush  = 1'b0;
        o_dx_en     = 1'b1;
        o_dx_bubble = 1'b0;
        o_xm_en     = 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (rst) begin
            // Flush NOPs through the unreset buffers while fetch is held.
            o_fetch_en  = 1'b0;
            o_fd_flush  = 1'b1;
            o_dx_bubble = 1'b1;
            state_d     = StRun;
            cnt_d       = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (i_mem_multi) begin
                        o_fetch_en = 1'b0;
                        o_fd_en    = 1'b0;
                        o_dx_en    = 1'b0;
                        o_xm_en    = 1'b0;
                        cnt_d      = MemLoad;
                        // The request cycle is the first frozen cycle; MemCycles=2 needs no more.
                        state_d    = (MemLoad == 4'd0) ? StRun : StMemStall;
                    end else if (i_branch_taken) begin
                        // The dependent decode instruction is flushed, so load-use is moot.
                        o_fd_flush  = 1'b1;
                        o_dx_bubble = 1'b1;
                    end else if (load_use) begin
                        o_fetch_en  = 1'b0;
                        o_fd_en     = 1'b0;
                        o_dx_bubble = 1'b1;
                        state_d     = StLoadStall;
                    end
                end
                StLoadStall: begin
                    state_d = StRun;
                end
                StMemStall: begin
                    // EX is frozen: branch/load-use are re-presented once back in RUN.
                    o_fetch_en = 1'b0;
                    o_fd_en    = 1'b0;
                    o_dx_en    = 1'b0;
                    o_xm_en    = 1'b0;
                    cnt_d      = cnt_q - 4'd1;
                    if (cnt_d == 4'd0) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!o_fetch_en && (stall_q != {CntWidth{1'b1}})) begin
            stall_d = stall_q + {{(CntWidth-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign o_stall_cycles = stall_q;

endmodule
